// File: rtl/sub_16bit_pipe.sv
// -----------------------------------------------------------------------------
// sub_16bit_pipe
//
// Two-stage pipelined subtractor computing diff = a - b - bin (mod 2^WIDTH),
// with borrow out and signed-overflow flag, and valid/ready handshakes on both
// sides. Stage 1 subtracts the low half and captures the mid borrow together
// with the high operand halves. Stage 2 finishes the high half and registers
// the results.
//
// Optional build macro:
//   SUB_SAT_EN - when defined, diff saturates to the max positive or min
//                negative value on signed overflow. The overflow flag is
//                still asserted and bout is unchanged. When undefined, diff
//                is the wrapped result and no saturation logic exists.
//
// Parameters:
//   WIDTH     operand/result width (even, >= 4); H = WIDTH/2
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle
//   a, b       minuend, subtrahend
//   bin        borrow in
//   out_valid  result valid
//   out_ready  consumer accepts result this cycle
//   diff       a - b - bin (wrapped, or saturated with SUB_SAT_EN)
//   bout       borrow out: 1 iff unsigned a < b + bin
//   overflow   signed overflow of the subtraction
// -----------------------------------------------------------------------------
module sub_16bit_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int H = WIDTH / 2;

`ifdef SUB_SAT_EN
  // Clamp toward the sign of the minuend: only the minuend's sign can be the
  // "true" sign when a signed subtraction overflows.
  function automatic logic [WIDTH-1:0] sat_diff(
    input logic [WIDTH-1:0] raw,
    input logic             ovf,
    input logic             a_msb
  );
    logic [WIDTH-1:0] max_pos;
    logic [WIDTH-1:0] min_neg;
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    if (!ovf)
      sat_diff = raw;
    else if (a_msb)
      sat_diff = min_neg;
    else
      sat_diff = max_pos;
  endfunction
`endif

  // Control
  logic vld_p1;
  logic vld_p2;
  logic s1_adv;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  assign s2_adv   = !vld_p2 || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;
  assign s2_load  = vld_p1 && s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (s1_adv) vld_p1 <= in_valid;
      if (s2_adv) vld_p2 <= vld_p1;
    end
  end

  assign out_valid = vld_p2;

  // ---- Stage 1: low-half subtraction, capture mid borrow and high halves ----
  logic [H:0]   lo_sub;
  logic [H-1:0] lo_p1;
  logic         mid_brw_p1;
  logic [H-1:0] a_hi_p1;
  logic [H-1:0] b_hi_p1;

  // The extra top bit of the (H+1)-bit result is the borrow into the high half.
  assign lo_sub = {1'b0, a[H-1:0]} - {1'b0, b[H-1:0]} - {{H{1'b0}}, bin};

  always_ff @(posedge clk) begin
    if (s1_load) begin
      lo_p1      <= lo_sub[H-1:0];
      mid_brw_p1 <= lo_sub[H];
      a_hi_p1    <= a[WIDTH-1:H];
      b_hi_p1    <= b[WIDTH-1:H];
    end
  end

  // ---- Stage 2: high-half subtraction, flags, optional saturation ----
  logic [H:0]       hi_sub;
  logic [WIDTH-1:0] diff_raw;
  logic             ovf_nxt;
  logic [WIDTH-1:0] diff_nxt;

  assign hi_sub   = {1'b0, a_hi_p1} - {1'b0, b_hi_p1} - {{H{1'b0}}, mid_brw_p1};
  assign diff_raw = {hi_sub[H-1:0], lo_p1};
  // Overflow only possible when operand signs differ; then the result must
  // carry the minuend's sign.
  assign ovf_nxt  = (a_hi_p1[H-1] ^ b_hi_p1[H-1]) & (diff_raw[WIDTH-1] ^ a_hi_p1[H-1]);

`ifdef SUB_SAT_EN
  assign diff_nxt = sat_diff(diff_raw, ovf_nxt, a_hi_p1[H-1]);
`else
  assign diff_nxt = diff_raw;
`endif

  // Result registers are cleared by reset so the outputs read zero while idle
  // after reset; otherwise they hold whenever stage 2 does not load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else if (s2_load) begin
      diff     <= diff_nxt;
      bout     <= hi_sub[H];
      overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_sub_16bit_pipe.sv
module tb_sub_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        overflow;

  int n_checks = 0;
  int n_err    = 0;

  sub_16bit_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    bin      = vbin;
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`ifdef SUB_SAT_EN
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
`else
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
`endif
    vecs[3] = '{16'h0100, 16'h00FF, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid_after", out_valid, 0);

    // Single operations: accept at one edge, result visible after the next
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].bin);
      check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", i), out_valid, 0);
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, 1);
      check($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
      check($sformatf("vec%0d_bout", i), bout, vecs[i].bout);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
      tick();
      check($sformatf("vec%0d_drained", i), out_valid, 0);
    end

    // Full-throughput stream: one result per cycle
    drive(16'd100, 16'd1, 1'b0);
    tick();
    drive(16'd200, 16'd2, 1'b0);
    tick();
    check("stream0_valid", out_valid, 1);
    check("stream0_diff", diff, 16'd99);
    drive(16'd300, 16'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("stream1_valid", out_valid, 1);
    check("stream1_diff", diff, 16'd198);
    tick();
    check("stream2_valid", out_valid, 1);
    check("stream2_diff", diff, 16'd297);
    tick();
    check("stream_drained", out_valid, 0);

    // Backpressure: two accepts fill the pipe, third waits for release
    out_ready = 1'b0;
    drive(16'd5, 16'd3, 1'b0);
    check("bp_ready0", in_ready, 1);
    tick();
    drive(16'd10, 16'd4, 1'b0);
    check("bp_ready1", in_ready, 1);
    tick();
    drive(16'd0, 16'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_stall%0d_ready", k), in_ready, 0);
      check($sformatf("bp_stall%0d_valid", k), out_valid, 1);
      check($sformatf("bp_stall%0d_diff", k), diff, 16'h0002);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_out1_valid", out_valid, 1);
    check("bp_out1_diff", diff, 16'h0006);
    tick();
    check("bp_out2_valid", out_valid, 1);
    check("bp_out2_diff", diff, 16'hFFFF);
    check("bp_out2_bout", bout, 1);
    tick();
    check("bp_drained", out_valid, 0);

    // Reset with both stages holding data
    out_ready = 1'b0;
    drive(16'h4444, 16'h1111, 1'b0);
    tick();
    drive(16'h5555, 16'h1111, 1'b0);
    tick();
    in_valid = 1'b0;
    check("mr_full_valid", out_valid, 1);
    check("mr_full_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mr_async_valid", out_valid, 0);
    check("mr_async_diff", diff, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mr_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mr_no_stale%0d", k), out_valid, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
